// File: rtl/fibo_pkg.sv
// Shared types and widths for the Fibonacci calculator and its request sequencer.
package fibo_pkg;

  localparam int FIBO_IDX_W = 5;
  localparam int FIBO_VAL_W = 16;

  typedef enum logic [1:0] {
    OK      = 2'b00,
    TIMEOUT = 2'b01,
    RANGE   = 2'b10
  } rsp_err_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ISSUE   = 2'b01,
    WAIT    = 2'b10,
    DELIVER = 2'b11
  } seq_state_e;

endpackage

// File: rtl/fibo_timeout_timer.sv
// Counts cycles spent waiting for the calculator; expired is high on the
// last permitted waiting cycle so the sequencer can leave on the next edge.
module fibo_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] r_count;

  // Saturates at LIMIT so a stalled enable can never wrap back to a live count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en && (r_count != LIMIT)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign expired = (r_count == LIMIT);

endmodule

// File: rtl/fibo_request_sequencer.sv
// Initiator-side sequencer: walks an index range through the Fibonacci
// calculator handshake and returns each result on a valid/ready stream.
module fibo_request_sequencer
  import fibo_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [FIBO_IDX_W-1:0] req_first,
  input  logic [FIBO_IDX_W-1:0] req_last,
  input  logic                  abort,
  output logic                  begin_fibo,
  output logic [FIBO_IDX_W-1:0] input_s,
  input  logic                  done,
  input  logic [FIBO_VAL_W-1:0] fibo_out,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [FIBO_IDX_W-1:0] rsp_index,
  output logic [FIBO_VAL_W-1:0] rsp_value,
  output logic                  rsp_last,
  output logic [1:0]            rsp_err
);

  seq_state_e            r_state;
  seq_state_e            w_state_next;
  logic [FIBO_IDX_W-1:0] r_cur;
  logic [FIBO_IDX_W-1:0] r_last_idx;
  logic                  r_begin_fibo;
  logic [FIBO_IDX_W-1:0] r_input_s;
  logic                  r_rsp_valid;
  logic [FIBO_IDX_W-1:0] r_rsp_index;
  logic [FIBO_VAL_W-1:0] r_rsp_value;
  logic                  r_rsp_last;
  rsp_err_e              r_rsp_err;
  logic                  w_expired;
  logic [FIBO_IDX_W-1:0] w_cur_inc;

  fibo_timeout_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (r_state == ISSUE),
    .en      (r_state == WAIT),
    .expired (w_expired)
  );

  assign w_cur_inc = r_cur + FIBO_IDX_W'(1);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_state_next = (req_first > req_last) ? DELIVER : ISSUE;
      ISSUE:   w_state_next = WAIT;
      WAIT:    if (done || w_expired) w_state_next = DELIVER;
      DELIVER: if (rsp_ready) w_state_next = r_rsp_last ? IDLE : ISSUE;
      default: w_state_next = IDLE;
    endcase
    if (abort) w_state_next = IDLE;
  end

  // begin_fibo is raised on the edge that enters ISSUE so the pulse lines up with that state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_cur        <= '0;
      r_last_idx   <= '0;
      r_begin_fibo <= 1'b0;
      r_input_s    <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_index  <= '0;
      r_rsp_value  <= '0;
      r_rsp_last   <= 1'b0;
      r_rsp_err    <= OK;
    end else begin
      r_state      <= w_state_next;
      r_begin_fibo <= 1'b0;
      if (abort) begin
        r_input_s   <= '0;
        r_rsp_valid <= 1'b0;
        r_rsp_index <= '0;
        r_rsp_value <= '0;
        r_rsp_last  <= 1'b0;
        r_rsp_err   <= OK;
      end else begin
        case (r_state)
          IDLE: begin
            if (req_valid) begin
              r_cur      <= req_first;
              r_last_idx <= req_last;
              if (req_first > req_last) begin
                r_rsp_valid <= 1'b1;
                r_rsp_index <= req_first;
                r_rsp_value <= '0;
                r_rsp_last  <= 1'b1;
                r_rsp_err   <= RANGE;
              end else begin
                r_begin_fibo <= 1'b1;
                r_input_s    <= req_first;
              end
            end
          end
          WAIT: begin
            if (done) begin
              r_rsp_valid <= 1'b1;
              r_rsp_index <= r_cur;
              r_rsp_value <= fibo_out;
              r_rsp_last  <= (r_cur == r_last_idx);
              r_rsp_err   <= OK;
            end else if (w_expired) begin
              r_rsp_valid <= 1'b1;
              r_rsp_index <= r_cur;
              r_rsp_value <= '0;
              r_rsp_last  <= 1'b1;
              r_rsp_err   <= TIMEOUT;
            end
          end
          DELIVER: begin
            if (rsp_ready) begin
              r_rsp_valid <= 1'b0;
              if (!r_rsp_last) begin
                r_cur        <= w_cur_inc;
                r_begin_fibo <= 1'b1;
                r_input_s    <= w_cur_inc;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign begin_fibo = r_begin_fibo;
  assign input_s    = r_input_s;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_index  = r_rsp_index;
  assign rsp_value  = r_rsp_value;
  assign rsp_last   = r_rsp_last;
  assign rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_fibo_request_sequencer.sv
// Directed and randomized sweeps against a calculator model and a list-based
// expectation of the responses each sweep should produce.
module tb_fibo_request_sequencer;

  typedef struct packed {
    logic [4:0]  idx;
    logic [15:0] val;
    logic        last;
    logic [1:0]  err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_first;
  logic [4:0]  req_last;
  logic        abort;
  logic        begin_fibo;
  logic [4:0]  input_s;
  logic        done;
  logic [15:0] fibo_out = 16'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [4:0]  rsp_index;
  logic [15:0] rsp_value;
  logic        rsp_last;
  logic [1:0]  rsp_err;

  logic        calc_done = 1'b0;
  logic        inj_done;
  logic        done_en;
  int          calc_cnt = 0;
  logic [4:0]  calc_idx = 5'd0;
  int          ready_mode = 1;
  int          cyc = 0;
  int          begin_count = 0;
  int          last_begin_cyc = 0;
  int          rise_delta = 0;
  logic        prev_valid = 1'b0;
  rsp_t        got[$];
  rsp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;

  assign done = calc_done | inj_done;

  fibo_request_sequencer #(.TIMEOUT_CYCLES(64)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_first (req_first),
    .req_last  (req_last),
    .abort     (abort),
    .begin_fibo(begin_fibo),
    .input_s   (input_s),
    .done      (done),
    .fibo_out  (fibo_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_index (rsp_index),
    .rsp_value (rsp_value),
    .rsp_last  (rsp_last),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  // Calculator: done five cycles after the begin_fibo cycle, result 100 + index.
  always @(negedge clk) begin
    calc_done = 1'b0;
    if (calc_cnt != 0) begin
      calc_cnt = calc_cnt - 1;
      if (calc_cnt == 0 && done_en) begin
        calc_done = 1'b1;
        fibo_out  = 16'(100 + int'(calc_idx));
      end
    end
    if (begin_fibo === 1'b1) begin
      calc_cnt = 5;
      calc_idx = input_s;
    end
  end

  // Consumer: drives rsp_ready and logs every handshake that the next edge will take.
  always @(negedge clk) begin
    cyc = cyc + 1;
    case (ready_mode)
      0:       rsp_ready = 1'b0;
      1:       rsp_ready = 1'b1;
      default: rsp_ready = 1'($urandom_range(0, 1));
    endcase
    if (begin_fibo === 1'b1) begin
      begin_count    = begin_count + 1;
      last_begin_cyc = cyc;
    end
    if (rsp_valid === 1'b1 && prev_valid !== 1'b1) rise_delta = cyc - last_begin_cyc;
    prev_valid = rsp_valid;
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1)
      got.push_back('{idx: rsp_index, val: rsp_value, last: rsp_last, err: rsp_err});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_outputs"}, 32'({begin_fibo, input_s, rsp_valid, rsp_index, rsp_value, rsp_last, rsp_err}), 32'd0);
  endtask

  // Expected response list for one sweep, straight from the sweep rules.
  task automatic model_sweep(input int first, input int last, input logic calc_ok);
    if (first > last)
      exp_q.push_back('{idx: 5'(first), val: 16'd0, last: 1'b1, err: 2'b10});
    else if (!calc_ok)
      exp_q.push_back('{idx: 5'(first), val: 16'd0, last: 1'b1, err: 2'b01});
    else
      for (int i = first; i <= last; i++)
        exp_q.push_back('{idx: 5'(i), val: 16'(100 + i), last: (i == last), err: 2'b00});
  endtask

  task automatic compare_rsps(input string tag);
    check({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got.size()) check($sformatf("%s_rsp%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
    got.delete();
    exp_q.delete();
  endtask

  task automatic start_req(input int first, input int last);
    req_valid = 1'b1;
    req_first = 5'(first);
    req_last  = 5'(last);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      if (got.size() >= exp_q.size() && req_ready === 1'b1) break;
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic wait_begin(input string tag, input int idx);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (begin_fibo === 1'b1 && input_s === 5'(idx)) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check(tag, 32'(found), 32'd1);
  endtask

  task automatic run_sweep(input string tag, input int first, input int last);
    int base;
    int n_begin;
    base    = begin_count;
    n_begin = (first > last) ? 0 : (!done_en ? 1 : last - first + 1);
    model_sweep(first, last, done_en);
    start_req(first, last);
    check({tag, "_begin_k1"}, 32'(begin_fibo), 32'(first <= last));
    wait_idle();
    compare_rsps(tag);
    check({tag, "_begins"}, 32'(begin_count - base), 32'(n_begin));
  endtask

  initial begin
    int base;
    reset_n   = 1'b1;
    req_valid = 1'b0;
    req_first = 5'd0;
    req_last  = 5'd0;
    abort     = 1'b0;
    inj_done  = 1'b0;
    done_en   = 1'b1;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    reset_n = 1'b1;
    @(negedge clk);

    run_sweep("sweep3_6", 3, 6);
    run_sweep("sweep31", 31, 31);
    run_sweep("range9_2", 9, 2);
    check("range_req_ready", 32'(req_ready), 32'd1);

    done_en = 1'b0;
    run_sweep("timeout", 0, 4);
    check("timeout_latency", 32'(rise_delta), 32'd65);
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    repeat (3) @(negedge clk);
    check("late_done_rsp", 32'(got.size()), 32'd0);
    check("late_done_valid", 32'(rsp_valid), 32'd0);
    done_en = 1'b1;

    // Consumer stalls for ten cycles on the first response of sweep 1..2.
    ready_mode = 0;
    base = begin_count;
    model_sweep(1, 2, 1'b1);
    start_req(1, 2);
    for (int i = 0; i < 50 && rsp_valid !== 1'b1; i++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("stall_fields%0d", i),
            32'({rsp_valid, rsp_index, rsp_value, rsp_last, rsp_err}),
            32'({1'b1, 5'd1, 16'd101, 1'b0, 2'b00}));
      check($sformatf("stall_begins%0d", i), 32'(begin_count - base), 32'd1);
      @(negedge clk);
    end
    ready_mode = 1;
    wait_idle();
    compare_rsps("stall");

    start_req(0, 5);
    wait_begin("abort_find_idx2", 2);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_idle("abort");
    repeat (8) @(negedge clk);
    check("abort_no_valid", 32'(rsp_valid), 32'd0);
    exp_q.push_back('{idx: 5'd0, val: 16'd100, last: 1'b0, err: 2'b00});
    exp_q.push_back('{idx: 5'd1, val: 16'd101, last: 1'b0, err: 2'b00});
    compare_rsps("abort");

    start_req(0, 5);
    wait_begin("rst_find_idx1", 1);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1 check_idle("rst_mid");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    check("rst_no_valid", 32'(rsp_valid), 32'd0);
    exp_q.push_back('{idx: 5'd0, val: 16'd100, last: 1'b0, err: 2'b00});
    compare_rsps("rst");

    ready_mode = 2;
    for (int t = 0; t < 8; t++) begin
      int f;
      int l;
      f = int'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0 && f > 0) l = int'($urandom_range(0, f - 1));
      else begin
        l = f + int'($urandom_range(0, 3));
        if (l > 31) l = 31;
      end
      run_sweep($sformatf("rand%0d_%0d_%0d", t, f, l), f, l);
    end
    ready_mode = 1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fibo_request_sequencer.md
# fibo_request_sequencer

Initiator-side controller for the Fibonacci calculator handshake. It accepts a sweep request for the index range first..last. For each index it issues a begin_fibo/input_s request to the calculator, waits for done, and captures fibo_out. Each result is returned on a valid/ready response stream tagged with its index, a last flag and a timeout flag. It sits between the host/test logic and the calculator, and it is the only driver of the calculator's request inputs.

## Interface
- TIMEOUT_CYCLES, 64: max cycles waited for done after a begin_fibo pulse; legal range 2..255.
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  sweep request valid.
- req_ready  out  1  high only in IDLE.
- req_first  in  5  first index of sweep.
- req_last  in  5  last index of sweep.
- abort  in  1  single-cycle pulse; cancels the sweep from any state.
- begin_fibo  out  1  one-cycle request pulse to the calculator; registered.
- input_s  out  5  index to the calculator; registered; stable from the begin_fibo cycle until the result is captured.
- done  in  1  one-cycle calculator completion pulse.
- fibo_out  in  16  calculator result; valid in the cycle done is high.
- rsp_valid  out  1  response valid; held until rsp_ready.
- rsp_ready  in  1  consumer ready.
- rsp_index  out  5  index of this response.
- rsp_value  out  16  captured fibo_out; 0 on timeout or range error.
- rsp_last  out  1  final response of the sweep.
- rsp_err  out  2  00 ok, 01 timeout, 10 range error (first > last).

## Operation
- Reset values (reset_n low): all outputs 0 except req_ready = 1; state IDLE; index and timer registers 0.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready, latch first/last and set cur = first.
  - If first > last, go to DELIVER with rsp_err = 10, rsp_index = first, rsp_value = 0, rsp_last = 1.
  - Otherwise go to ISSUE.
- ISSUE: one cycle; begin_fibo = 1, input_s = cur; clear timer; go to WAIT.
- WAIT:
  - Timer increments every cycle.
  - done high: capture rsp_value = fibo_out, rsp_index = cur, rsp_err = 00, rsp_last = (cur == last); go to DELIVER.
  - Timer reaches TIMEOUT_CYCLES without done: rsp_value = 0, rsp_err = 01, rsp_last = 1; go to DELIVER. The sweep terminates.
  - done and timeout expiry in the same cycle: done wins.
- DELIVER:
  - rsp_valid = 1; all rsp_* fields held stable until rsp_ready.
  - On rsp_valid & rsp_ready: if rsp_last, go to IDLE; else cur = cur + 1 and go to ISSUE.
- abort:
  - In any state, the next state is IDLE; rsp_valid, begin_fibo and rsp_err are cleared.
  - Abort in the same cycle as a response handshake: the handshake completes, the sweep still ends.
- done outside WAIT is ignored (late results after abort or timeout are discarded).
- Index arithmetic is 5-bit unsigned. cur never increments past last, so no wrap; first = last = 31 is legal.
- Reset asserted mid-sweep: all state returns to reset values immediately (asynchronous); no response is emitted.

## Timing
- Request handshake at edge k → begin_fibo high during cycle k+1 only.
- done high in cycle m → rsp_valid high from cycle m+1.
- Response handshake at edge r (non-last) → next begin_fibo in cycle r+1.
- Per-index overhead beyond calculator latency: 2 cycles (ISSUE plus DELIVER with rsp_ready held high).
- Timeout: rsp_valid rises TIMEOUT_CYCLES+1 cycles after the begin_fibo cycle.
- rsp_valid never depends combinationally on rsp_ready; req_ready depends only on state.

## Structure
- Package fibo_pkg:
  - FIBO_IDX_W = 5, FIBO_VAL_W = 16.
  - Response error enum (OK, TIMEOUT, RANGE).
  - Sequencer state enum (IDLE, ISSUE, WAIT, DELIVER).
  - Shared with the calculator.
- One sub-module, fibo_timeout_timer: clear/enable inputs, expired output, width $clog2(TIMEOUT_CYCLES+1).
- Single always_ff for state and datapath; next-state logic in always_comb.

## Test plan
- Bench calculator model: asserts done 5 cycles after begin_fibo, with fibo_out = 100 + input_s.
- Sweep first=3, last=6, rsp_ready tied high → four responses, index 3..6, values 103..106, rsp_last only on index 6, rsp_err 00; begin_fibo pulsed exactly 4 times.
- Sweep first=31, last=31 → one response: index 31, value 131, rsp_last 1.
- first=9, last=2 → no begin_fibo; one response: index 9, value 0, rsp_err 10, rsp_last 1; req_ready returns 1 after handshake.
- Model never asserts done, TIMEOUT_CYCLES=64, sweep 0..4 → single response after 65 cycles: index 0, rsp_err 01, rsp_last 1; a late done injected afterward is ignored.
- rsp_ready held low 10 cycles in sweep 1..2 → rsp fields stable throughout; no second begin_fibo until the handshake.
- abort during WAIT of index 2 in sweep 0..5, and separately reset_n pulsed low mid-sweep → IDLE next cycle, all outputs at reset values except req_ready 1; the model's subsequent done produces no response.
